// File: rtl/dma_if_pcie_wr_tx_limit.sv
// dma_if_pcie_wr_tx_limit: in-flight TLP and posted-credit admission gate with multi-port sequence-number retirement.
// Define DMA_IF_PCIE_WR_TX_LIMIT_SEQ_CHECK_EN to track outstanding sequence numbers and flag bad returns on err_seq.
module dma_if_pcie_wr_tx_limit #(
  parameter int RQ_SEQ_NUM_WIDTH = 6,
  parameter int SEQ_PORTS = 2,
  parameter int TX_LIMIT = 2**(RQ_SEQ_NUM_WIDTH-1),
  parameter int TX_FC_ENABLE = 1,
  parameter int FC_HOLDOFF = 2,
  parameter int LEN_DW_WIDTH = 11,
  localparam int W = RQ_SEQ_NUM_WIDTH,
  localparam int CW = $clog2(TX_LIMIT+1),
  localparam int DW = $clog2(SEQ_PORTS+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_DW_WIDTH-1:0] s_tx_req_len,
  input  logic                    s_tx_req_valid,
  output logic                    s_tx_req_ready,
  output logic [W-1:0]            m_tx_seq_num,
  input  logic [SEQ_PORTS*W-1:0]  s_seq_num,
  input  logic [SEQ_PORTS-1:0]    s_seq_num_valid,
  input  logic [7:0]              pcie_tx_fc_ph_av,
  input  logic [11:0]             pcie_tx_fc_pd_av,
  input  logic                    enable,
  output logic [CW-1:0]           inflight_count,
  output logic [DW-1:0]           done_count,
  output logic                    err_underflow,
  output logic                    err_seq
);
  logic [W-1:0] seq_cnt;
  logic [2:0] holdoff_cnt;
  logic fc_ok;
  logic accept;
  logic underflow;
  logic [SEQ_PORTS-1:0] ret_ok;
  logic [DW-1:0] r;
  logic [31:0] sum;
  // One posted data credit covers 4 DW, so the TLP needs ceil(len/4) credits.
  assign fc_ok = TX_FC_ENABLE == 0 ||
                 (pcie_tx_fc_ph_av != 8'd0 && 32'(pcie_tx_fc_pd_av) >= (32'(s_tx_req_len) + 32'd3) >> 2);
  assign s_tx_req_ready = !rst && enable && 32'(inflight_count) < 32'(TX_LIMIT) && holdoff_cnt == 3'd0 && fc_ok;
  assign accept = s_tx_req_valid && s_tx_req_ready;
  assign m_tx_seq_num = seq_cnt;
  always_comb begin
    r = '0;
    for (int k = 0; k < SEQ_PORTS; k++) r = r + DW'(ret_ok[k]);
  end
  assign sum = 32'(inflight_count) + 32'(accept);
  assign underflow = 32'(r) > sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seq_cnt <= '0;
      holdoff_cnt <= '0;
      inflight_count <= '0;
      done_count <= '0;
      err_underflow <= 1'b0;
    end else begin
      seq_cnt <= seq_cnt + W'(accept);
      holdoff_cnt <= (TX_FC_ENABLE != 0 && accept) ? 3'(FC_HOLDOFF) : holdoff_cnt - 3'(holdoff_cnt != 3'd0);
      inflight_count <= underflow ? '0 : CW'(sum - 32'(r));
      done_count <= r;
      err_underflow <= err_underflow || underflow;
    end
`ifdef DMA_IF_PCIE_WR_TX_LIMIT_SEQ_CHECK_EN
  logic [2**W-1:0] bitmap;
  logic [2**W-1:0] bitmap_nxt;
  logic [SEQ_PORTS-1:0] dup;
  // A repeat of a sequence number already strobed on a lower port this cycle is a duplicate.
  always_comb begin
    dup = '0;
    for (int k = 1; k < SEQ_PORTS; k++)
      for (int j = 0; j < k; j++)
        dup[k] = dup[k] || (s_seq_num_valid[j] && s_seq_num[j*W +: W] == s_seq_num[k*W +: W]);
  end
  // A same-cycle accept of a sequence number takes precedence over its return.
  always_comb begin
    ret_ok = '0;
    bitmap_nxt = bitmap;
    for (int k = 0; k < SEQ_PORTS; k++) begin
      ret_ok[k] = s_seq_num_valid[k] && bitmap[s_seq_num[k*W +: W]] && !dup[k] &&
                  !(accept && s_seq_num[k*W +: W] == seq_cnt);
      if (ret_ok[k]) bitmap_nxt[s_seq_num[k*W +: W]] = 1'b0;
    end
    if (accept) bitmap_nxt[seq_cnt] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bitmap <= '0;
      err_seq <= 1'b0;
    end else begin
      bitmap <= bitmap_nxt;
      err_seq <= err_seq || (s_seq_num_valid & ~ret_ok) != '0;
    end
`else
  logic unused_seq_num;
  assign unused_seq_num = ^s_seq_num;
  assign ret_ok = s_seq_num_valid;
  assign err_seq = 1'b0;
`endif
endmodule

// File: doc/dma_if_pcie_wr_tx_limit.md
# dma_if_pcie_wr_tx_limit

Outstanding-TLP and transmit-credit gate for the PCIe write DMA path. Sits between the write-TLP generator and the requester-request (RQ) AXI stream, admits one TLP per handshake, tags it with a request sequence number, and retires in-flight TLPs from any of `SEQ_PORTS` sequence-number return ports. It generalises the fixed two-port sequence-number handling to 1–4 return ports, and adds configurable flow-control hold-off, underflow detection and optional per-sequence-number checking.

## Interface
- `RQ_SEQ_NUM_WIDTH`, 6: sequence number width.
- `SEQ_PORTS`, 2: number of sequence-number return ports, 1..4.
- `TX_LIMIT`, 2**(RQ_SEQ_NUM_WIDTH-1): maximum number of TLPs in flight; must be ≤ 2**RQ_SEQ_NUM_WIDTH.
- `TX_FC_ENABLE`, 1: gate admission on posted header/data credits.
- `FC_HOLDOFF`, 2: cycles ready is held low after each accept when `TX_FC_ENABLE`=1; 0..7.
- `LEN_DW_WIDTH`, 11: payload length field width, in dwords.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_tx_req_len` in LEN_DW_WIDTH: payload length in dwords, 1..1024.
- `s_tx_req_valid` in 1: TLP admission request.
- `s_tx_req_ready` out 1: admission granted.
- `m_tx_seq_num` out RQ_SEQ_NUM_WIDTH: sequence number for the current request; valid whenever `s_tx_req_valid` is high.
- `s_seq_num` in SEQ_PORTS*RQ_SEQ_NUM_WIDTH: returned sequence numbers; port k occupies bits [k*W +: W].
- `s_seq_num_valid` in SEQ_PORTS: per-port return strobe.
- `pcie_tx_fc_ph_av` in 8: posted header credits available.
- `pcie_tx_fc_pd_av` in 12: posted data credits available; one credit is 4 DW.
- `enable` in 1: admission enable.
- `inflight_count` out $clog2(TX_LIMIT+1): current in-flight count.
- `done_count` out $clog2(SEQ_PORTS+1): number of retirements accepted last cycle.
- `err_underflow` out 1: sticky; a return arrived with nothing in flight.
- `err_seq` out 1: sticky; only present when checking is compiled in, otherwise tied 0.

## Operation
- Accept occurs when `s_tx_req_valid && s_tx_req_ready`.
- `s_tx_req_ready` = `enable` && `inflight_count < TX_LIMIT` && `holdoff_cnt == 0` && fc_ok.
- fc_ok = `pcie_tx_fc_ph_av ≥ 1` && `pcie_tx_fc_pd_av ≥ ceil(len/4)`. fc_ok is forced to 1 when `TX_FC_ENABLE`=0.
- `s_tx_req_ready` is combinational from registered state, `s_tx_req_len` and the FC inputs. It does not depend on `s_tx_req_valid`.
- `m_tx_seq_num` = `seq_cnt`. `seq_cnt` increments by 1 per accept and wraps modulo 2**W (63→0 at W=6).
- On accept, `holdoff_cnt` loads `FC_HOLDOFF` and then decrements to 0. When `TX_FC_ENABLE`=0, `holdoff_cnt` is never loaded.
- Retirement count `r` = popcount of `s_seq_num_valid`, excluding invalid returns when checking is enabled.
- Next in-flight count = `inflight_count + accept − r`, saturating at 0.
- Saturation occurs when `r > inflight_count + accept`. On saturation, `err_underflow` sets and holds until reset.
- `done_count` = `r`, registered.
- Simultaneous accept and return in one cycle are both applied. The net change can therefore be 0.
- Deasserting `enable` blocks new accepts only; returns continue to retire.

## Timing
- Admission is zero-latency: ready is combinational.
- `seq_cnt`, `inflight_count` and `holdoff_cnt` update on the clock edge after an accept.
- Returns affect `inflight_count` and `done_count` one cycle later.
- At `inflight_count == TX_LIMIT` ready is low. A return in cycle N re-enables ready in cycle N+1.
- Reset values: `inflight_count`=0, `done_count`=0, `seq_cnt`=0, `holdoff_cnt`=0, `err_underflow`=0, `err_seq`=0, outstanding bitmap all 0.
- `s_tx_req_ready` is 0 during reset and thereafter follows the ready equation.
- Reset asserted mid-operation discards all in-flight state. Returns arriving after reset for pre-reset TLPs count as underflow.

## Configuration
- `DMA_IF_PCIE_WR_TX_LIMIT_SEQ_CHECK_EN` defined:
  - Adds a 2**W-bit outstanding bitmap. An accept sets `bitmap[seq]`; a valid return clears it.
  - A return for a clear bit, or a second return of the same sequence number in the same cycle, sets `err_seq` and is excluded from `r`.
  - Accept and return of the same sequence number in the same cycle: the accept wins and the return is treated as invalid.
- Not defined: no bitmap; every strobe counts toward `r`; `err_seq` is tied 0.

## Test plan
- Reset, enable=1, ph=8, pd=256, `TX_FC_ENABLE`=0, 40 back-to-back requests with no returns → exactly 32 accepts with `m_tx_seq_num` 0..31, ready low at `inflight_count`=32.
- One return of seq 5 at port 0 → `done_count`=1 one cycle later, `inflight_count`=31, the next accept gets seq 32.
- 100 accepts with immediate in-order returns on alternating ports → `m_tx_seq_num` wraps 63→0; `inflight_count` never exceeds 1; `err_*`=0.
- `TX_FC_ENABLE`=1, `FC_HOLDOFF`=2, pd=3, len=16 → no accept. Raise pd to 4 → accept, then ready low for exactly 2 cycles.
- Idle block, `SEQ_PORTS`=4, all four strobes high → `inflight_count` stays 0, `err_underflow`=1 and stays 1 until reset.
- With the macro defined: return of a never-issued seq 9 → `err_seq`=1 and `inflight_count` unchanged. Duplicate seq 3 on ports 0 and 1 in the same cycle → one retirement counted and `err_seq`=1.
